// File: rtl/data_mem_resp_pkg.sv
// ----------------------------------------------------------------------------
// data_mem_resp_pkg
//   Shared definitions for the data memory responder: FSM state encoding,
//   response status codes and the word-index width helper.
// ----------------------------------------------------------------------------
package data_mem_resp_pkg;

    // Encodings are fixed so waveforms and any external monitors agree.
    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StWait = 2'd1,
        StResp = 2'd2
    } state_e;

    // Response status carried on resp_err.
    localparam logic RespOk  = 1'b0;
    localparam logic RespErr = 1'b1;

    localparam int unsigned WordBits = 32;
    localparam int unsigned CntBits  = 4;   // holds WAIT_STATES-1 for WAIT_STATES up to 15

    // ceil(log2(depth)), at least 1 so a 2-word store still gets an index bit.
    function automatic int unsigned idx_width(input int unsigned depth);
        int unsigned w;
        w = 1;
        for (int i = 1; i < 32; i++) begin
            if ((32'd1 << i) < depth) begin
                w = i + 1;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/mem_word_array.sv
// ----------------------------------------------------------------------------
// mem_word_array
//   DEPTH_WORDS x 32-bit register store with asynchronous active-low clear,
//   one synchronous write port and one combinational read port. Read and write
//   share a single index because the responder only ever touches one word per
//   request.
// Ports
//   clk    in   rising-edge clock
//   reset  in   asynchronous active-low clear of every word
//   we     in   write enable
//   index  in   word index for both read and write
//   wdata  in   write data (all 32 bits written)
//   rdata  out  combinational read of mem[index] (pre-write value on a write edge)
// ----------------------------------------------------------------------------
module mem_word_array
    import data_mem_resp_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 64,
    parameter int unsigned IDX_W       = 6
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                we,
    input  logic [IDX_W-1:0]    index,
    input  logic [WordBits-1:0] wdata,
    output logic [WordBits-1:0] rdata
);

    logic [WordBits-1:0] mem_q [DEPTH_WORDS];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH_WORDS; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we) begin
            mem_q[index] <= wdata;
        end
    end

    assign rdata = mem_q[index];

endmodule

// File: rtl/data_mem_responder.sv
// ----------------------------------------------------------------------------
// data_mem_responder
//   Memory-side responder for the CPU load/store port. Accepts one request per
//   valid/ready handshake, spends WAIT_STATES cycles in WAIT, then presents a
//   registered response (load data or store ack) until the requester takes it.
//   Misaligned or out-of-window addresses are answered with resp_err=1 and
//   rdata=0 and never modify the store.
// Parameters
//   DEPTH_WORDS  number of 32-bit words (power of 2, >= 2)
//   WAIT_STATES  cycles spent in WAIT between accept and response (0..15)
//   BASE_ADDR    byte address of word 0 (aligned to DEPTH_WORDS*4)
// Ports
//   clk         in   rising-edge clock
//   reset       in   asynchronous active-low reset
//   req_valid   in   request present
//   req_ready   out  high only in IDLE; accept = req_valid & req_ready
//   req_write   in   1 = store, 0 = load
//   req_addr    in   byte address
//   req_wdata   in   store data
//   resp_valid  out  response present, held until resp_ready
//   resp_ready  in   requester takes the response
//   resp_rdata  out  load data (0 for stores and errors)
//   resp_err    out  misaligned or out-of-range address
// ----------------------------------------------------------------------------
module data_mem_responder
    import data_mem_resp_pkg::*;
#(
    parameter int unsigned          DEPTH_WORDS = 64,
    parameter int unsigned          WAIT_STATES = 2,
    parameter logic [WordBits-1:0]  BASE_ADDR   = 32'h1001_0000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_write,
    input  logic [WordBits-1:0] req_addr,
    input  logic [WordBits-1:0] req_wdata,
    output logic                resp_valid,
    input  logic                resp_ready,
    output logic [WordBits-1:0] resp_rdata,
    output logic                resp_err
);

    localparam int unsigned        IdxW     = idx_width(DEPTH_WORDS);
    localparam logic [CntBits-1:0] WaitLoad =
        (WAIT_STATES > 0) ? CntBits'(WAIT_STATES - 1) : '0;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    state_e              state_q, state_d;
    logic [CntBits-1:0]  cnt_q, cnt_d;
    logic                write_q;
    logic [WordBits-1:0] addr_q;
    logic [WordBits-1:0] wdata_q;
    logic [WordBits-1:0] rdata_q, rdata_d;
    logic                err_q, err_d;

    logic                accept;
    logic                enter_resp;

    // With zero wait states the response is produced on the accept edge, so the
    // address check and store must look at the live request rather than the latch.
    logic                cur_write;
    logic [WordBits-1:0] cur_addr;
    logic [WordBits-1:0] cur_wdata;
    logic [29:0]         word_off;
    logic                cur_err;
    logic [IdxW-1:0]     mem_index;
    logic [WordBits-1:0] mem_rdata;
    logic                mem_we;

    assign accept = req_valid && (state_q == StIdle);

    always_comb begin
        if (state_q == StIdle) begin
            cur_write = req_write;
            cur_addr  = req_addr;
            cur_wdata = req_wdata;
        end else begin
            cur_write = write_q;
            cur_addr  = addr_q;
            cur_wdata = wdata_q;
        end
    end

    // Word offset computed on the word-aligned part only; alignment is checked
    // separately on the low two bits. The range compare is a full 32-bit
    // unsigned compare so addresses below BASE_ADDR cannot wrap into range.
    assign word_off  = cur_addr[31:2] - BASE_ADDR[31:2];
    assign cur_err   = (cur_addr[1:0] != 2'b00)
                    || (cur_addr < BASE_ADDR)
                    || ({2'b00, word_off} >= 32'(DEPTH_WORDS));
    assign mem_index = word_off[IdxW-1:0];

    // Edge entering RESP: both the store commit and the load sample happen here.
    always_comb begin
        enter_resp = 1'b0;
        if (state_q == StIdle) begin
            enter_resp = accept && (WAIT_STATES == 0);
        end else if (state_q == StWait) begin
            enter_resp = (cnt_q == '0);
        end
    end

    assign mem_we = enter_resp && cur_write && !cur_err;

    mem_word_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .IDX_W       (IdxW)
    ) u_mem (
        .clk   (clk),
        .reset (reset),
        .we    (mem_we),
        .index (mem_index),
        .wdata (cur_wdata),
        .rdata (mem_rdata)
    );

    // ------------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (req_valid) begin
                    state_d = (WAIT_STATES == 0) ? StResp : StWait;
                end
            end
            StWait: begin
                if (cnt_q == '0) begin
                    state_d = StResp;
                end
            end
            StResp: begin
                if (resp_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // ------------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------------
    always_comb begin
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        unique case (state_q)
            StIdle:  req_ready  = 1'b1;
            StResp:  resp_valid = 1'b1;
            default: ;
        endcase
    end

    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;

    // ------------------------------------------------------------------------
    // Wait counter and response registers
    // ------------------------------------------------------------------------
    always_comb begin
        cnt_d = cnt_q;
        if (accept) begin
            cnt_d = WaitLoad;
        end else if ((state_q == StWait) && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_comb begin
        rdata_d = rdata_q;
        err_d   = err_q;
        if (enter_resp) begin
            err_d   = cur_err ? RespErr : RespOk;
            rdata_d = (cur_err || cur_write) ? '0 : mem_rdata;
        end else if ((state_q == StResp) && resp_ready) begin
            rdata_d = '0;
            err_d   = RespOk;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q   <= '0;
            rdata_q <= '0;
            err_q   <= RespOk;
        end else begin
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Request latch: captured on accept, ignored until the next accept.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            write_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (accept) begin
            write_q <= req_write;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
        end
    end

endmodule
